// File: rtl/sqrt_pkg.sv
// Widths, constants and FSM encoding shared by the half-precision sqrt core and its bench.
package sqrt_pkg;
  localparam int MANT_W = 11;
  localparam int EXP_W  = 7;
  localparam int ROOT_W = MANT_W + 1;
  localparam int RAD_W  = 2 * ROOT_W;
  localparam int REM_W  = ROOT_W + 2;
  localparam int ITER_W = $clog2(ROOT_W);
  localparam int BIAS   = 15;

  localparam logic signed [EXP_W-1:0] ZERO_EXP = EXP_W'(-BIAS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/sqrt_core_if.sv
// Operand channel from normalize and result channel to pack/round for the sqrt core.
interface sqrt_op_if;
  import sqrt_pkg::*;

  logic                    n_valid;
  logic                    in_ready;
  logic                    is_num;
  logic                    is_nan;
  logic                    is_pinf;
  logic                    is_ninf;
  logic                    sign_in;
  logic signed [EXP_W-1:0] exp_in;
  logic [MANT_W-1:0]       mant_in;

  modport master (
    output n_valid, is_num, is_nan, is_pinf, is_ninf, sign_in, exp_in, mant_in,
    input  in_ready
  );
  modport slave (
    input  n_valid, is_num, is_nan, is_pinf, is_ninf, sign_in, exp_in, mant_in,
    output in_ready
  );
endinterface

interface sqrt_res_if;
  import sqrt_pkg::*;

  logic                    r_valid;
  logic                    res_is_num;
  logic                    res_is_nan;
  logic                    res_is_pinf;
  logic                    res_sign;
  logic signed [EXP_W-1:0] res_exp;
  logic [MANT_W-1:0]       res_mant;
  logic                    res_guard;
  logic                    res_sticky;

  modport master (
    output r_valid, res_is_num, res_is_nan, res_is_pinf, res_sign,
           res_exp, res_mant, res_guard, res_sticky
  );
  modport slave (
    input  r_valid, res_is_num, res_is_nan, res_is_pinf, res_sign,
           res_exp, res_mant, res_guard, res_sticky
  );
endinterface

// File: rtl/sqrt_iter_step.sv
// One restoring square-root step: bring down two radicand bits, try subtracting (4q+1), keep if non-negative.
module sqrt_iter_step
  import sqrt_pkg::*;
(
  input  logic [REM_W-1:0]  rem,
  input  logic [1:0]        rad_pair,
  input  logic [ROOT_W-1:0] q,
  output logic [REM_W-1:0]  rem_next,
  output logic              q_bit
);
  logic [REM_W+1:0] shifted;
  logic [REM_W+1:0] trial;

  // Compared at full width so no radicand bits are lost; the remainder bound keeps the result in REM_W.
  assign shifted  = {rem, rad_pair};
  assign trial    = {2'b00, q, 2'b01};
  assign q_bit    = (shifted >= trial);
  assign rem_next = q_bit ? REM_W'(shifted - trial) : REM_W'(shifted);
endmodule

// File: rtl/sqrt_core.sv
// Restoring sqrt, one root bit/cycle: numbers 13 cycles accept-to-r_valid (14 with SQRT_CORE_ROUND_EN), specials 1.
// in_ready only in IDLE; no output backpressure; operands arriving while busy are dropped and set sticky overrun.
module sqrt_core
  import sqrt_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  sqrt_op_if.slave   op,
  sqrt_res_if.master res,
  output logic       overrun
);
  state_t                  state;
  state_t                  state_nxt;
  logic                    accept;
  logic                    fire;
  logic                    done_last;

  logic                    cls_nan;
  logic                    cls_pinf;
  logic                    cls_zero;
  logic                    cls_calc;

  logic                    p_nan;
  logic                    p_pinf;
  logic                    p_zero;
  logic                    p_calc;
  logic                    p_sign;
  logic signed [EXP_W-1:0] exp_r;

  logic [ITER_W-1:0]       iter;
  logic [RAD_W-1:0]        rad;
  logic [REM_W-1:0]        rem;
  logic [REM_W-1:0]        rem_nxt;
  logic [ROOT_W-1:0]       q;
  logic                    q_bit;

  logic [MANT_W-1:0]       out_mant;
  logic signed [EXP_W-1:0] out_exp;
  logic                    out_guard;
  logic                    out_sticky;

  assign op.in_ready = (state == IDLE);

  always_comb begin
    cls_nan  = 1'b1;
    cls_pinf = 1'b0;
    cls_zero = 1'b0;
    cls_calc = 1'b0;
    if (op.is_nan || op.is_ninf) begin
      cls_nan = 1'b1;
    end else if (op.is_pinf) begin
      cls_nan  = 1'b0;
      cls_pinf = 1'b1;
    end else if (op.is_num) begin
      if (op.mant_in == '0) begin
        cls_nan  = 1'b0;
        cls_zero = 1'b1;
      end else if (!op.sign_in) begin
        cls_nan  = 1'b0;
        cls_calc = 1'b1;
      end
    end
  end

  sqrt_iter_step u_step (
    .rem      (rem),
    .rad_pair (rad[RAD_W-1 -: 2]),
    .q        (q),
    .rem_next (rem_nxt),
    .q_bit    (q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    fire      = 1'b0;
    unique case (state)
      IDLE: begin
        if (op.n_valid) begin
          accept    = 1'b1;
          state_nxt = cls_calc ? CALC : DONE;
        end
      end
      CALC: begin
        if (iter == '0) state_nxt = DONE;
      end
      DONE: begin
        if (done_last) begin
          fire      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (!enable) begin
      state_nxt = IDLE;
      accept    = 1'b0;
      fire      = 1'b0;
    end
  end

`ifdef SQRT_CORE_ROUND_EN
  logic                    round_ph;
  logic [MANT_W-1:0]       rnd_mant;
  logic signed [EXP_W-1:0] rnd_exp;
  logic [MANT_W:0]         rnd_sum;

  // Round to nearest even on q[11:1]: round up when guard is set and either sticky or the lsb is set.
  assign rnd_sum = {1'b0, q[ROOT_W-1:1]} + (MANT_W+1)'(q[0] & ((rem != '0) | q[1]));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      round_ph <= 1'b0;
      rnd_mant <= '0;
      rnd_exp  <= '0;
    end else if (!enable) begin
      round_ph <= 1'b0;
      rnd_mant <= '0;
      rnd_exp  <= '0;
    end else if (state == DONE && p_calc && !round_ph) begin
      round_ph <= 1'b1;
      rnd_mant <= rnd_sum[MANT_W] ? {1'b1, {(MANT_W-1){1'b0}}} : rnd_sum[MANT_W-1:0];
      rnd_exp  <= rnd_sum[MANT_W] ? exp_r + EXP_W'(1) : exp_r;
    end else if (fire) begin
      round_ph <= 1'b0;
    end
  end

  assign done_last  = !p_calc || round_ph;
  assign out_mant   = rnd_mant;
  assign out_exp    = rnd_exp;
  assign out_guard  = 1'b0;
  assign out_sticky = 1'b0;
`else
  assign done_last  = 1'b1;
  assign out_mant   = q[ROOT_W-1:1];
  assign out_exp    = exp_r;
  assign out_guard  = q[0];
  assign out_sticky = (rem != '0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_nan           <= 1'b0;
      p_pinf          <= 1'b0;
      p_zero          <= 1'b0;
      p_calc          <= 1'b0;
      p_sign          <= 1'b0;
      exp_r           <= '0;
      iter            <= '0;
      rad             <= '0;
      rem             <= '0;
      q               <= '0;
      overrun         <= 1'b0;
      res.r_valid     <= 1'b0;
      res.res_is_num  <= 1'b0;
      res.res_is_nan  <= 1'b0;
      res.res_is_pinf <= 1'b0;
      res.res_sign    <= 1'b0;
      res.res_exp     <= '0;
      res.res_mant    <= '0;
      res.res_guard   <= 1'b0;
      res.res_sticky  <= 1'b0;
    end else if (!enable) begin
      p_nan           <= 1'b0;
      p_pinf          <= 1'b0;
      p_zero          <= 1'b0;
      p_calc          <= 1'b0;
      p_sign          <= 1'b0;
      exp_r           <= '0;
      iter            <= '0;
      rad             <= '0;
      rem             <= '0;
      q               <= '0;
      overrun         <= 1'b0;
      res.r_valid     <= 1'b0;
      res.res_is_num  <= 1'b0;
      res.res_is_nan  <= 1'b0;
      res.res_is_pinf <= 1'b0;
      res.res_sign    <= 1'b0;
      res.res_exp     <= '0;
      res.res_mant    <= '0;
      res.res_guard   <= 1'b0;
      res.res_sticky  <= 1'b0;
    end else begin
      res.r_valid <= 1'b0;
      if (op.n_valid && state != IDLE) overrun <= 1'b1;

      if (accept) begin
        p_nan  <= cls_nan;
        p_pinf <= cls_pinf;
        p_zero <= cls_zero;
        p_calc <= cls_calc;
        p_sign <= op.sign_in;
        exp_r  <= op.exp_in >>> 1;
        iter   <= ITER_W'(ROOT_W - 1);
        rem    <= '0;
        q      <= '0;
        // Odd exponents fold the leftover factor of two into the radicand.
        rad    <= op.exp_in[0] ? {op.mant_in, {(RAD_W-MANT_W){1'b0}}}
                               : {1'b0, op.mant_in, {(RAD_W-MANT_W-1){1'b0}}};
      end

      if (state == CALC) begin
        rem  <= rem_nxt;
        q    <= {q[ROOT_W-2:0], q_bit};
        rad  <= {rad[RAD_W-3:0], 2'b00};
        iter <= iter - 1'b1;
      end

      if (fire) begin
        res.r_valid     <= 1'b1;
        res.res_is_num  <= p_zero | p_calc;
        res.res_is_nan  <= p_nan;
        res.res_is_pinf <= p_pinf;
        res.res_sign    <= p_zero & p_sign;
        res.res_exp     <= p_zero ? ZERO_EXP : (p_calc ? out_exp : '0);
        res.res_mant    <= p_calc ? out_mant : '0;
        res.res_guard   <= p_calc & out_guard;
        res.res_sticky  <= p_calc & out_sticky;
      end
    end
  end
endmodule

// File: tb/tb_sqrt_core.sv
// Bench for sqrt_core: directed corner cases plus random operands against an integer-sqrt reference model.
module tb_sqrt_core;
  import sqrt_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic overrun;
  int   n_chk = 0;
  int   n_pass = 0;

  sqrt_op_if  op_if ();
  sqrt_res_if res_if ();

  sqrt_core dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (enable),
    .op      (op_if.slave),
    .res     (res_if.master),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit num, nan, pinf, ninf, sign;
    int e;
    int m;
  } opnd_t;

  typedef struct {
    bit num, nan, pinf, sign;
    int e;
    int m;
    bit g, s;
    int lat;
  } want_t;

  task automatic check(input string tag, input longint got, input longint want);
    n_chk++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", tag, got, got, want, want);
  endtask

  function automatic opnd_t mk(bit num, bit nan, bit pinf, bit ninf, bit sign, int e, int m);
    opnd_t o;
    o.num = num; o.nan = nan; o.pinf = pinf; o.ninf = ninf; o.sign = sign; o.e = e; o.m = m;
    return o;
  endfunction

  function automatic longint isqrt(longint x);
    longint r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  function automatic want_t model(opnd_t o);
    want_t  w;
    longint rad;
    longint q;
    w.num = 0; w.nan = 0; w.pinf = 0; w.sign = 0;
    w.e = 0; w.m = 0; w.g = 0; w.s = 0; w.lat = 1;
    if (o.nan || o.ninf || !(o.num || o.pinf) || (o.num && o.sign && o.m != 0)) begin
      w.nan = 1;
    end else if (o.pinf) begin
      w.pinf = 1;
    end else if (o.m == 0) begin
      w.num = 1; w.sign = o.sign; w.e = -15;
    end else begin
      w.num = 1;
      w.lat = 13;
      w.e   = o.e >>> 1;
      rad   = (o.e % 2 != 0) ? longint'(o.m) * 8192 : longint'(o.m) * 4096;
      q     = isqrt(rad);
      w.m   = int'(q >> 1);
      w.g   = q[0];
      w.s   = (q * q != rad);
    end
    return w;
  endfunction

  task automatic drive(opnd_t o);
    op_if.n_valid = 1'b1;
    op_if.is_num  = o.num;
    op_if.is_nan  = o.nan;
    op_if.is_pinf = o.pinf;
    op_if.is_ninf = o.ninf;
    op_if.sign_in = o.sign;
    op_if.exp_in  = 7'(o.e);
    op_if.mant_in = 11'(o.m);
  endtask

  // Returns at the falling edge right after the accepting rising edge.
  task automatic launch(opnd_t o, string tag);
    @(negedge clk);
    check({tag, ".ready"}, op_if.in_ready, 1);
    drive(o);
    @(negedge clk);
    op_if.n_valid = 1'b0;
    check({tag, ".busy"}, op_if.in_ready, 0);
  endtask

  task automatic collect(opnd_t o, int lat0, string tag);
    want_t w;
    int    lat;
    w   = model(o);
    lat = lat0;
    while (!res_if.r_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ".lat"},    lat, w.lat);
    check({tag, ".num"},    res_if.res_is_num, w.num);
    check({tag, ".nan"},    res_if.res_is_nan, w.nan);
    check({tag, ".pinf"},   res_if.res_is_pinf, w.pinf);
    check({tag, ".sign"},   res_if.res_sign, w.sign);
    check({tag, ".exp"},    longint'(res_if.res_exp), w.e);
    check({tag, ".mant"},   res_if.res_mant, w.m);
    check({tag, ".guard"},  res_if.res_guard, w.g);
    check({tag, ".sticky"}, res_if.res_sticky, w.s);
    check({tag, ".idle"},   op_if.in_ready, 1);
    @(negedge clk);
    check({tag, ".pulse"},  res_if.r_valid, 0);
    check({tag, ".hold"},   res_if.res_mant, w.m);
  endtask

  task automatic run(opnd_t o, string tag);
    launch(o, tag);
    collect(o, 0, tag);
  endtask

  opnd_t two;
  opnd_t four;

  initial begin
    op_if.n_valid = 1'b0;
    op_if.is_num  = 1'b0;
    op_if.is_nan  = 1'b0;
    op_if.is_pinf = 1'b0;
    op_if.is_ninf = 1'b0;
    op_if.sign_in = 1'b0;
    op_if.exp_in  = '0;
    op_if.mant_in = '0;
    enable = 1'b1;
    two  = mk(1, 0, 0, 0, 0, 1, 'h400);
    four = mk(1, 0, 0, 0, 0, 2, 'h400);

    repeat (2) @(negedge clk);
    check("rst.ready",   op_if.in_ready, 1);
    check("rst.valid",   res_if.r_valid, 0);
    check("rst.mant",    res_if.res_mant, 0);
    check("rst.num",     res_if.res_is_num, 0);
    check("rst.overrun", overrun, 0);
    rst_n = 1'b1;

    run(four, "four");
    run(two, "two");
    run(mk(1, 0, 0, 0, 1, 2, 'h400), "neg4");
    run(mk(1, 0, 0, 0, 1, 0, 0), "negzero");
    run(mk(0, 0, 1, 0, 0, 0, 0), "pinf");
    run(mk(0, 1, 0, 0, 0, 0, 0), "nan");
    run(mk(0, 0, 0, 1, 1, 0, 0), "ninf");
    run(mk(1, 0, 0, 0, 0, -24, 'h400), "minsub");
    run(mk(1, 0, 0, 0, 0, -15, 'h400), "em15");
    run(mk(1, 0, 0, 0, 0, 15, 'h7FF), "maxnorm");

    // Second operand arrives mid-calculation and must be ignored.
    launch(two, "ovr");
    repeat (5) @(negedge clk);
    drive(four);
    @(negedge clk);
    op_if.n_valid = 1'b0;
    collect(two, 6, "ovr");
    check("ovr.flag", overrun, 1);
    repeat (3) @(negedge clk);
    check("ovr.sticky", overrun, 1);

    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    check("clr.overrun", overrun, 0);
    check("clr.mant",    res_if.res_mant, 0);
    check("clr.ready",   op_if.in_ready, 1);

    launch(two, "abort");
    repeat (3) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    check("abort.ready", op_if.in_ready, 1);
    repeat (14) @(negedge clk);
    check("abort.novalid", res_if.r_valid, 0);
    run(four, "after_abort");

    launch(two, "arst");
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst.ready", op_if.in_ready, 1);
    check("arst.exp",   longint'(res_if.res_exp), 0);
    check("arst.num",   res_if.res_is_num, 0);
    check("arst.valid", res_if.r_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run(two, "after_arst");

    for (int i = 0; i < 40; i++) begin
      int    k;
      opnd_t o;
      k = $urandom_range(0, 9);
      o = mk(0, 0, 0, 0, $urandom_range(0, 1) != 0, $urandom_range(0, 80) - 40,
             'h400 | $urandom_range(0, 'h3FF));
      case (k)
        0: o.nan  = 1;
        1: o.pinf = 1;
        2: o.ninf = 1;
        3: begin o.num = 1; o.m = 0; end
        4: begin o.num = 1; o.sign = 1; end
        default: begin o.num = 1; o.sign = 0; end
      endcase
      run(o, "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sqrt_core.md
Name: sqrt_core

Overview:
- Iterative square-root stage; sits directly downstream of the normalize stage in the half-precision sqrt pipeline.
- Consumes the classified, unbiased-exponent, implicit-bit mantissa operand and produces the root's sign, unbiased exponent, 11-bit mantissa and guard/sticky bits for the pack/round stage.
- Uses restoring digit-by-digit extraction, one root bit per cycle.

Parameters:
- MANT_W, 11, mantissa width incl. implicit bit
- EXP_W, 7, signed unbiased exponent width
- ROOT_W, 12, root bits extracted (MANT_W + 1 guard); also the iteration count

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  synchronous clear when low
- n_valid  in  1  operand valid pulse from normalize
- in_ready  out  1  high only in IDLE
- is_num / is_nan / is_pinf / is_ninf  in  1 each  operand class
- sign_in  in  1  operand sign
- exp_in  in  EXP_W  signed unbiased exponent
- mant_in  in  MANT_W  1.10 mantissa; 0 for ±0
- r_valid  out  1  one-cycle result pulse
- res_is_num / res_is_nan / res_is_pinf  out  1 each  result class
- res_sign  out  1  result sign
- res_exp  out  EXP_W  signed unbiased result exponent
- res_mant  out  MANT_W  root mantissa incl. implicit bit
- res_guard  out  1  next root bit below res_mant
- res_sticky  out  1  remainder non-zero
- overrun  out  1  sticky: n_valid seen while busy

Behaviour:
- Reset and !enable:
  - All outputs 0, in_ready 1 (IDLE).
  - rst_n is asynchronous; enable is sampled on clk.
  - Both abort any operation in flight and clear overrun.
- FSM states: IDLE, CALC, DONE. in_ready = (state==IDLE).
- IDLE, n_valid high → accept. The class determines the path:
  - Special or zero → DONE directly; r_valid is visible after edge E+1.
  - +num non-zero → CALC with iter=ROOT_W-1.
- Special-case results:
  - NaN → NaN.
  - -Inf → NaN.
  - +Inf → +Inf.
  - ±0 → is_num, sign kept, mant 0, exp -15.
  - Negative non-zero number → NaN.
  - NaN results have res_sign=0.
- Exponent:
  - res_exp = exp_in >>> 1 (arithmetic).
  - odd = exp_in[0] (two's complement, valid for negatives).
- Radicand (2*ROOT_W = 24 bits):
  - Even exponent: {1'b0, mant_in, 12'b0}.
  - Odd exponent: {mant_in, 13'b0}.
  - Root q (ROOT_W bits) = floor(sqrt(rad)); its value is q/2^11, in [1,2).
- CALC: one restoring step per cycle, MSB first; remainder is ROOT_W+2 bits wide.
  - Exactly 12 CALC cycles, then DONE.
  - Number latency: accept at edge E0 → r_valid visible after E13.
- DONE:
  - r_valid=1 for exactly one cycle.
  - res_mant=q[11:1], res_guard=q[0], res_sticky=(rem!=0).
  - Next state IDLE.
  - Earliest next accept is the edge after r_valid.
- Result fields hold their values until the next r_valid or a clear.
- n_valid while not IDLE: operand dropped, overrun←1 (held until reset or !enable).
- No output backpressure; the consumer must take r_valid when it is asserted.

Optional Feature:
- Macro: SQRT_CORE_ROUND_EN.
- Defined:
  - DONE applies round-to-nearest-even on q[11:1] using guard/sticky.
  - Mantissa overflow (0x7FF+1) → res_mant=0x400, res_exp+1.
  - res_guard/res_sticky are driven 0.
  - One extra DONE cycle, so number latency is 14.
- Undefined: result is truncated; guard and sticky are exported raw.

Decomposition:
- sqrt_pkg holds:
  - MANT_W, EXP_W, ROOT_W, BIAS=15
  - State enum {IDLE, CALC, DONE}
  - ZERO_EXP=-15
- Sub-module sqrt_iter_step (combinational), one restoring step:
  - Inputs: rem, rad pair, q.
  - Outputs: next rem, next q bit.

Test Plan:
- 4.0 (exp=2, mant=0x400, +num) → 13 cycles later r_valid: exp=1, mant=0x400, guard=0, sticky=0.
- 2.0 (exp=1, mant=0x400) → q=0xB50: res_exp=0, res_mant=0x5A8, guard=0, sticky=1. With ROUND_EN: mant=0x5A8, latency 14.
- Class paths, each → r_valid 1 cycle after accept:
  - -4.0 → res_is_nan=1.
  - -0 → is_num, sign=1, mant=0.
  - +Inf → pinf=1.
  - NaN → nan=1.
- Min subnormal (exp=-24, mant=0x400) → res_exp=-12, mant=0x400, sticky=0. exp=-15, mant=0x400 → res_exp=-8, res_mant=0x5A8, sticky=1.
- n_valid pulsed 5 cycles into CALC → second operand ignored, overrun=1, first result unchanged.
- rst_n low mid-CALC → outputs 0 asynchronously, in_ready=1; fresh operand then completes normally.
